// File: rtl/dm_bridge_pkg.sv
// Shared types and AXI encodings for the CPU data-memory to AXI4 bridge.
package dm_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_D,
    S_WR_AW,
    S_WR_B,
    S_HOLD
  } dm_state_t;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dm_perf_cnt.sv
// Wrapping 32-bit event counters for bridge loads, stores and stall cycles.
module dm_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_done_i,
  input  logic        wr_done_i,
  input  logic        stall_i,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (rd_done_i) rd_cnt_q    <= rd_cnt_q + 32'd1;
      if (wr_done_i) wr_cnt_q    <= wr_cnt_q + 32'd1;
      if (stall_i)   stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/dm_axi_bridge.sv
// CPU MEM-stage load/store to single-beat AXI4 master bridge with pipeline stall.
// Define DM_AXI_BRIDGE_PERF_EN to add the perf_*_cnt counter outputs.
module dm_axi_bridge
  import dm_bridge_pkg::*;
#(
  parameter int unsigned     ADDR_W    = 32,
  parameter int unsigned     DATA_W    = 32,
  parameter int unsigned     ID_W      = 4,
  parameter logic [ID_W-1:0] MASTER_ID = 4'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_read,
  input  logic              DM_write,
  input  logic [3:0]        DM_BWEB,
  input  logic [ADDR_W-1:0] DM_addr,
  input  logic [DATA_W-1:0] DM_DI,
  input  logic              IM_stall,
  output logic [DATA_W-1:0] DM_DO,
  output logic              DM_stall,
  output logic              bus_err,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [ID_W-1:0]   AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [3:0]        WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [ID_W-1:0]   BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
`ifdef DM_AXI_BRIDGE_PERF_EN
  ,
  output logic [31:0]       perf_rd_cnt,
  output logic [31:0]       perf_wr_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  dm_state_t         state_q;
  logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic              aw_done_q, w_done_q, bus_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, dm_do_q;
  logic [3:0]        wstrb_q;
  logic              aw_done_d, w_done_d;
  logic              wr_has_strb;
  logic              dm_stall_c;
  logic              unused_ok;

  assign wr_has_strb = (~DM_BWEB != 4'h0);
  assign aw_done_d   = aw_done_q | (awvalid_q & AWREADY);
  assign w_done_d    = w_done_q  | (wvalid_q  & WREADY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bus_err_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      dm_do_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (DM_write) begin
            if (dm_read) bus_err_q <= 1'b1;
            if (wr_has_strb) begin
              state_q   <= S_WR_AW;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              addr_q    <= DM_addr;
              wdata_q   <= DM_DI;
              wstrb_q   <= ~DM_BWEB;
            end else if (IM_stall) begin
              state_q <= S_HOLD;
            end
          end else if (dm_read) begin
            state_q   <= S_RD_A;
            arvalid_q <= 1'b1;
            addr_q    <= DM_addr;
          end
        end
        S_RD_A: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_D;
          end
        end
        S_RD_D: begin
          if (RVALID) begin
            rready_q <= 1'b0;
            dm_do_q  <= RDATA;
            if (RRESP != AXI_RESP_OKAY) bus_err_q <= 1'b1;
            state_q  <= IM_stall ? S_HOLD : S_IDLE;
          end
        end
        S_WR_AW: begin
          // AW and W complete independently; B is only accepted once both have fired.
          if (AWREADY) awvalid_q <= 1'b0;
          if (WREADY)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            state_q   <= S_WR_B;
            bready_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
          end
        end
        S_WR_B: begin
          if (BVALID) begin
            bready_q <= 1'b0;
            if (BRESP != AXI_RESP_OKAY) bus_err_q <= 1'b1;
            state_q  <= IM_stall ? S_HOLD : S_IDLE;
          end
        end
        S_HOLD: begin
          if (!IM_stall) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    dm_stall_c = 1'b0;
    case (state_q)
      S_IDLE:          dm_stall_c = DM_write ? wr_has_strb : dm_read;
      S_RD_A, S_WR_AW: dm_stall_c = 1'b1;
      S_RD_D:          dm_stall_c = ~RVALID;
      S_WR_B:          dm_stall_c = ~BVALID;
      default:         dm_stall_c = 1'b0;
    endcase
  end

  assign DM_stall = rst & dm_stall_c;
  // Load data is forwarded on the completion cycle so the CPU can sample it as the stall drops.
  assign DM_DO    = (state_q == S_RD_D && RVALID) ? RDATA : dm_do_q;
  assign bus_err  = bus_err_q;

  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = '0;
  assign ARSIZE  = AXI_SIZE_WORD;
  assign ARBURST = AXI_BURST_INCR;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = '0;
  assign AWSIZE  = AXI_SIZE_WORD;
  assign AWBURST = AXI_BURST_INCR;
  assign AWVALID = awvalid_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = 1'b1;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;

  assign unused_ok = ^{RID, BID, RLAST};

`ifdef DM_AXI_BRIDGE_PERF_EN
  logic ld_done, st_done;

  assign ld_done = (state_q == S_RD_D) & RVALID;
  assign st_done = ((state_q == S_WR_B) & BVALID) |
                   ((state_q == S_IDLE) & DM_write & ~wr_has_strb);

  dm_perf_cnt u_perf (
    .clk         (clk),
    .rst         (rst),
    .rd_done_i   (ld_done),
    .wr_done_i   (st_done),
    .stall_i     (DM_stall),
    .rd_cnt_o    (perf_rd_cnt),
    .wr_cnt_o    (perf_wr_cnt),
    .stall_cnt_o (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_dm_axi_bridge.sv
// Directed self-checking bench for dm_axi_bridge (default build).
module tb_dm_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        dm_read, DM_write, IM_stall;
  logic [3:0]  DM_BWEB;
  logic [31:0] DM_addr, DM_DI, DM_DO;
  logic        DM_stall, bus_err;
  logic [3:0]  ARID, AWID, RID, BID;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [7:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [3:0]  WSTRB;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int ar_hs    = 0;

  dm_axi_bridge #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .MASTER_ID(4'd1)) dut (
    .clk(clk), .rst(rst), .dm_read(dm_read), .DM_write(DM_write), .DM_BWEB(DM_BWEB),
    .DM_addr(DM_addr), .DM_DI(DM_DI), .IM_stall(IM_stall), .DM_DO(DM_DO),
    .DM_stall(DM_stall), .bus_err(bus_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst && ARVALID && ARREADY) ar_hs++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; dm_read = 0; DM_write = 0; IM_stall = 0; DM_BWEB = 4'hF;
    DM_addr = '0; DM_DI = '0; ARREADY = 0; RID = 4'd1; RDATA = '0; RRESP = 0;
    RLAST = 1; RVALID = 0; AWREADY = 0; WREADY = 0; BID = 4'd1; BRESP = 0; BVALID = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (ARVALID !== 1'b0) $display("FAIL rst_arvalid got=%b exp=0", ARVALID); else pass_cnt++;
    chk_cnt++; if (RREADY !== 1'b0) $display("FAIL rst_rready got=%b exp=0", RREADY); else pass_cnt++;
    chk_cnt++; if (AWVALID !== 1'b0) $display("FAIL rst_awvalid got=%b exp=0", AWVALID); else pass_cnt++;
    chk_cnt++; if (WVALID !== 1'b0) $display("FAIL rst_wvalid got=%b exp=0", WVALID); else pass_cnt++;
    chk_cnt++; if (BREADY !== 1'b0) $display("FAIL rst_bready got=%b exp=0", BREADY); else pass_cnt++;
    chk_cnt++; if (DM_DO !== 32'h0) $display("FAIL rst_dm_do got=%h exp=0", DM_DO); else pass_cnt++;
    chk_cnt++; if (bus_err !== 1'b0) $display("FAIL rst_bus_err got=%b exp=0", bus_err); else pass_cnt++;
    chk_cnt++; if (DM_stall !== 1'b0) $display("FAIL rst_stall got=%b exp=0", DM_stall); else pass_cnt++;
    #2 rst = 1'b1;
  endtask

  task automatic test_load();
    int stalls;
    stalls = 0;
    tick(); dm_read = 1; DM_addr = 32'h0000_0100; ARREADY = 1; #1;
    chk_cnt++; if (DM_stall !== 1'b1) $display("FAIL ld_stall_idle got=%b exp=1", DM_stall); else pass_cnt++;
    if (DM_stall) stalls++;
    tick(); #1;
    chk_cnt++; if (ARVALID !== 1'b1) $display("FAIL ld_arvalid got=%b exp=1", ARVALID); else pass_cnt++;
    chk_cnt++; if (ARADDR !== 32'h100) $display("FAIL ld_araddr got=%h exp=100", ARADDR); else pass_cnt++;
    chk_cnt++; if ({ARID, ARLEN, ARSIZE, ARBURST} !== {4'd1, 8'd0, 3'b010, 2'b01})
      $display("FAIL ld_ar_const got=%h/%h/%b/%b exp=1/00/010/01", ARID, ARLEN, ARSIZE, ARBURST); else pass_cnt++;
    if (DM_stall) stalls++;
    tick(); RVALID = 1; RDATA = 32'h1234_5678; RRESP = 2'b00; #1;
    chk_cnt++; if (RREADY !== 1'b1) $display("FAIL ld_rready got=%b exp=1", RREADY); else pass_cnt++;
    chk_cnt++; if (ARVALID !== 1'b0) $display("FAIL ld_arvalid_drop got=%b exp=0", ARVALID); else pass_cnt++;
    chk_cnt++; if (DM_stall !== 1'b0) $display("FAIL ld_stall_done got=%b exp=0", DM_stall); else pass_cnt++;
    chk_cnt++; if (DM_DO !== 32'h1234_5678) $display("FAIL ld_dm_do got=%h exp=12345678", DM_DO); else pass_cnt++;
    chk_cnt++; if (stalls !== 2) $display("FAIL ld_stall_cycles got=%0d exp=2", stalls); else pass_cnt++;
    tick(); dm_read = 0; RVALID = 0; RDATA = '0; ARREADY = 0; #1;
    chk_cnt++; if (DM_DO !== 32'h1234_5678) $display("FAIL ld_dm_do_held got=%h exp=12345678", DM_DO); else pass_cnt++;
    chk_cnt++; if (RREADY !== 1'b0) $display("FAIL ld_rready_drop got=%b exp=0", RREADY); else pass_cnt++;
    chk_cnt++; if (bus_err !== 1'b0) $display("FAIL ld_bus_err got=%b exp=0", bus_err); else pass_cnt++;
  endtask

  // aw_first=1: AWREADY on WR_AW cycle 1, WREADY on cycle 3; aw_first=0: the reverse.
  task automatic test_store_order(input bit aw_first);
    tick(); DM_write = 1; DM_BWEB = 4'b1100; DM_DI = 32'hA5A5_0F0F; DM_addr = 32'h0000_0200; #1;
    chk_cnt++; if (DM_stall !== 1'b1) $display("FAIL st%0d_stall_idle got=%b exp=1", aw_first, DM_stall); else pass_cnt++;
    tick(); AWREADY = aw_first; WREADY = !aw_first; #1;
    chk_cnt++; if ({AWVALID, WVALID} !== 2'b11) $display("FAIL st%0d_valids got=%b exp=11", aw_first, {AWVALID, WVALID}); else pass_cnt++;
    chk_cnt++; if (WSTRB !== 4'b0011) $display("FAIL st%0d_wstrb got=%b exp=0011", aw_first, WSTRB); else pass_cnt++;
    chk_cnt++; if ({AWADDR, WDATA} !== {32'h200, 32'hA5A5_0F0F}) $display("FAIL st%0d_addr_data got=%h %h exp=200 a5a50f0f", aw_first, AWADDR, WDATA); else pass_cnt++;
    chk_cnt++; if ({WLAST, AWLEN, AWSIZE, AWBURST, AWID} !== {1'b1, 8'd0, 3'b010, 2'b01, 4'd1})
      $display("FAIL st%0d_aw_const got=%b/%h/%b/%b/%h", aw_first, WLAST, AWLEN, AWSIZE, AWBURST, AWID); else pass_cnt++;
    tick(); AWREADY = 0; WREADY = 0; #1;
    chk_cnt++; if ({AWVALID, WVALID} !== {!aw_first, aw_first}) $display("FAIL st%0d_one_drop got=%b exp=%b", aw_first, {AWVALID, WVALID}, {!aw_first, aw_first}); else pass_cnt++;
    chk_cnt++; if (BREADY !== 1'b0) $display("FAIL st%0d_bready_early1 got=%b exp=0", aw_first, BREADY); else pass_cnt++;
    chk_cnt++; if (DM_stall !== 1'b1) $display("FAIL st%0d_stall_wait got=%b exp=1", aw_first, DM_stall); else pass_cnt++;
    tick(); AWREADY = !aw_first; WREADY = aw_first; #1;
    chk_cnt++; if (BREADY !== 1'b0) $display("FAIL st%0d_bready_early2 got=%b exp=0", aw_first, BREADY); else pass_cnt++;
    tick(); AWREADY = 0; WREADY = 0; BVALID = 0; #1;
    chk_cnt++; if ({AWVALID, WVALID, BREADY} !== 3'b001) $display("FAIL st%0d_wr_b got=%b exp=001", aw_first, {AWVALID, WVALID, BREADY}); else pass_cnt++;
    chk_cnt++; if (DM_stall !== 1'b1) $display("FAIL st%0d_stall_b got=%b exp=1", aw_first, DM_stall); else pass_cnt++;
    BVALID = 1; BRESP = 2'b00; #1;
    chk_cnt++; if (DM_stall !== 1'b0) $display("FAIL st%0d_stall_done got=%b exp=0", aw_first, DM_stall); else pass_cnt++;
    tick(); DM_write = 0; DM_BWEB = 4'hF; BVALID = 0; #1;
    chk_cnt++; if ({BREADY, DM_stall, bus_err} !== 3'b000) $display("FAIL st%0d_idle got=%b exp=000", aw_first, {BREADY, DM_stall, bus_err}); else pass_cnt++;
  endtask

  task automatic test_zero_strobe();
    tick(); DM_write = 1; DM_BWEB = 4'hF; DM_DI = 32'hFFFF_0000; DM_addr = 32'h0000_0300; #1;
    chk_cnt++; if (DM_stall !== 1'b0) $display("FAIL zs_stall got=%b exp=0", DM_stall); else pass_cnt++;
    tick(); DM_write = 0; #1;
    chk_cnt++; if ({AWVALID, WVALID, ARVALID} !== 3'b000) $display("FAIL zs_valids got=%b exp=000", {AWVALID, WVALID, ARVALID}); else pass_cnt++;
    tick(); #1;
    chk_cnt++; if ({AWVALID, WVALID, DM_stall} !== 3'b000) $display("FAIL zs_quiet got=%b exp=000", {AWVALID, WVALID, DM_stall}); else pass_cnt++;
  endtask

  task automatic test_hold();
    int base;
    base = ar_hs;
    tick(); dm_read = 1; DM_addr = 32'h0000_0700; ARREADY = 1; #1;
    tick(); #1;
    tick(); RVALID = 1; RDATA = 32'hCAFE_F00D; IM_stall = 1; #1;
    chk_cnt++; if (DM_DO !== 32'hCAFE_F00D) $display("FAIL hold_do_done got=%h exp=cafef00d", DM_DO); else pass_cnt++;
    for (int h = 0; h < 3; h++) begin
      tick(); RVALID = 0; RDATA = 32'h0BAD_0BAD; #1;
      chk_cnt++; if (DM_stall !== 1'b0) $display("FAIL hold_stall%0d got=%b exp=0", h, DM_stall); else pass_cnt++;
      chk_cnt++; if (DM_DO !== 32'hCAFE_F00D) $display("FAIL hold_do%0d got=%h exp=cafef00d", h, DM_DO); else pass_cnt++;
      chk_cnt++; if (ARVALID !== 1'b0) $display("FAIL hold_arvalid%0d got=%b exp=0", h, ARVALID); else pass_cnt++;
    end
    IM_stall = 0; #1;
    chk_cnt++; if (DM_stall !== 1'b0) $display("FAIL hold_release got=%b exp=0", DM_stall); else pass_cnt++;
    tick(); dm_read = 0; ARREADY = 0; #1;
    chk_cnt++; if (ARVALID !== 1'b0) $display("FAIL hold_reissue got=%b exp=0", ARVALID); else pass_cnt++;
    chk_cnt++; if (ar_hs - base !== 1) $display("FAIL hold_ar_count got=%0d exp=1", ar_hs - base); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    tick(); dm_read = 1; DM_addr = 32'h0000_0400; ARREADY = 1; #1;
    tick(); #1;
    tick(); RVALID = 1; RDATA = 32'h0000_BEEF; #1;
    tick(); RVALID = 0; ARREADY = 0; dm_read = 0;
    DM_write = 1; DM_BWEB = 4'b0000; DM_DI = 32'h1122_3344; DM_addr = 32'h0000_0404; #1;
    chk_cnt++; if (DM_stall !== 1'b1) $display("FAIL b2b_accept_stall got=%b exp=1", DM_stall); else pass_cnt++;
    chk_cnt++; if (DM_DO !== 32'h0000_BEEF) $display("FAIL b2b_do got=%h exp=0000beef", DM_DO); else pass_cnt++;
    tick(); AWREADY = 1; WREADY = 1; #1;
    chk_cnt++; if ({AWVALID, WVALID, WSTRB} !== 6'b11_1111) $display("FAIL b2b_aw got=%b exp=111111", {AWVALID, WVALID, WSTRB}); else pass_cnt++;
    chk_cnt++; if (WDATA !== 32'h1122_3344) $display("FAIL b2b_wdata got=%h exp=11223344", WDATA); else pass_cnt++;
    tick(); AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b00; #1;
    chk_cnt++; if ({BREADY, DM_stall} !== 2'b10) $display("FAIL b2b_b got=%b exp=10", {BREADY, DM_stall}); else pass_cnt++;
    tick(); DM_write = 0; DM_BWEB = 4'hF; BVALID = 0; #1;
  endtask

  task automatic test_bus_err();
    tick(); DM_write = 1; DM_BWEB = 4'b0000; DM_DI = 32'h0; DM_addr = 32'h0000_0500; #1;
    tick(); AWREADY = 1; WREADY = 1; #1;
    tick(); AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b10; #1;
    chk_cnt++; if (DM_stall !== 1'b0) $display("FAIL berr_stall got=%b exp=0", DM_stall); else pass_cnt++;
    tick(); DM_write = 0; DM_BWEB = 4'hF; BVALID = 0; BRESP = 2'b00; #1;
    chk_cnt++; if (bus_err !== 1'b1) $display("FAIL berr_set got=%b exp=1", bus_err); else pass_cnt++;
    tick(); dm_read = 1; DM_addr = 32'h0000_0504; ARREADY = 1; #1;
    tick(); #1;
    tick(); RVALID = 1; RDATA = 32'hDEAD_BEEF; RRESP = 2'b00; #1;
    tick(); dm_read = 0; ARREADY = 0; RVALID = 0; #1;
    chk_cnt++; if (bus_err !== 1'b1) $display("FAIL berr_sticky got=%b exp=1", bus_err); else pass_cnt++;
    chk_cnt++; if (DM_DO !== 32'hDEAD_BEEF) $display("FAIL berr_load_do got=%h exp=deadbeef", DM_DO); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    tick(); dm_read = 1; DM_addr = 32'h0000_0600; ARREADY = 0; #1;
    tick(); #1;
    chk_cnt++; if (ARVALID !== 1'b1) $display("FAIL rmid_arvalid_hold got=%b exp=1", ARVALID); else pass_cnt++;
    ARREADY = 1;
    tick(); ARREADY = 0; #1;
    chk_cnt++; if (RREADY !== 1'b1) $display("FAIL rmid_rready got=%b exp=1", RREADY); else pass_cnt++;
    #2 rst = 1'b0; #1;
    chk_cnt++; if ({ARVALID, RREADY, DM_stall} !== 3'b000) $display("FAIL rmid_ctrl got=%b exp=000", {ARVALID, RREADY, DM_stall}); else pass_cnt++;
    chk_cnt++; if (DM_DO !== 32'h0) $display("FAIL rmid_do got=%h exp=0", DM_DO); else pass_cnt++;
    chk_cnt++; if (bus_err !== 1'b0) $display("FAIL rmid_bus_err got=%b exp=0", bus_err); else pass_cnt++;
    dm_read = 0;
    tick(); #2 rst = 1'b1;
    tick(); #1;
    chk_cnt++; if ({ARVALID, RREADY, DM_stall} !== 3'b000) $display("FAIL rmid_after got=%b exp=000", {ARVALID, RREADY, DM_stall}); else pass_cnt++;
  endtask

  task automatic test_dual_request();
    tick(); dm_read = 1; DM_write = 1; DM_BWEB = 4'b0000; DM_DI = 32'h55AA_55AA; DM_addr = 32'h0000_0800; #1;
    chk_cnt++; if (DM_stall !== 1'b1) $display("FAIL dual_stall got=%b exp=1", DM_stall); else pass_cnt++;
    tick(); AWREADY = 1; WREADY = 1; #1;
    chk_cnt++; if ({AWVALID, WVALID, ARVALID} !== 3'b110) $display("FAIL dual_write_wins got=%b exp=110", {AWVALID, WVALID, ARVALID}); else pass_cnt++;
    chk_cnt++; if (bus_err !== 1'b1) $display("FAIL dual_bus_err got=%b exp=1", bus_err); else pass_cnt++;
    tick(); AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b00; #1;
    chk_cnt++; if (DM_stall !== 1'b0) $display("FAIL dual_done got=%b exp=0", DM_stall); else pass_cnt++;
    tick(); dm_read = 0; DM_write = 0; DM_BWEB = 4'hF; BVALID = 0; #1;
    chk_cnt++; if ({ARVALID, AWVALID, DM_stall} !== 3'b000) $display("FAIL dual_idle got=%b exp=000", {ARVALID, AWVALID, DM_stall}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_order(1'b1);
    test_store_order(1'b0);
    test_zero_strobe();
    test_hold();
    test_back_to_back();
    test_bus_err();
    test_reset_mid();
    test_dual_request();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dm_axi_bridge.md
Name: dm_axi_bridge

Overview:
- Sits between the CPU data-memory (MEM-stage) port and the system AXI4 bus; it is the downstream consumer of the CPU's DM request signals.
- Converts each CPU load/store into one single-beat AXI4 transaction.
- Drives DM_stall to freeze the pipeline while the transaction is outstanding, then returns read data on DM_DO.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (only 32 is supported).
- ID_W, 4, AXI ID width.
- MASTER_ID, 4'd1, constant driven on ARID/AWID.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- dm_read  in  1  CPU load request (MEM-stage MemRead)
- DM_write  in  1  CPU store request
- DM_BWEB  in  4  active-low byte write enables
- DM_addr  in  ADDR_W  byte address
- DM_DI  in  DATA_W  store data
- IM_stall  in  1  instruction-side stall; pipeline holds while high
- DM_DO  out  DATA_W  load data
- DM_stall  out  1  pipeline freeze request
- bus_err  out  1  sticky error flag, cleared only by reset
- AR/R channel (master side):
  - ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID  out
  - ARREADY  in
  - RID, RDATA, RRESP, RLAST, RVALID  in
  - RREADY  out
- AW/W/B channel (master side):
  - AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID  out
  - AWREADY  in
  - WDATA, WSTRB, WLAST, WVALID  out
  - WREADY  in
  - BID, BRESP, BVALID  in
  - BREADY  out

Behaviour:
- Reset values (rst low, asynchronous): state IDLE; all VALID/READY outputs 0; DM_DO 0; bus_err 0; aw_done and w_done 0.
- Constant outputs: LEN 0, SIZE 3'b010, BURST 2'b01, WLAST 1. ADDR, WDATA and WSTRB are registered at request acceptance.
- DM_stall is combinational:
  - 1 in IDLE when a new request is present.
  - 1 in all wait states.
  - 0 in the completion cycle, in HOLD, and in IDLE with no request.
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, HOLD.
- IDLE:
  - DM_write=1 with ~DM_BWEB != 0: go to WR_AW, asserting AWVALID and WVALID together.
  - DM_write=1 with DM_BWEB=4'hF: no bus transaction and no stall; treat as completed.
  - dm_read=1: go to RD_A.
  - dm_read and DM_write both 1: the write wins and bus_err is set.
- RD_A: hold ARVALID until ARREADY, then go to RD_D with RREADY=1.
- RD_D: on RVALID, capture RDATA into DM_DO.
  - RRESP != 0 sets bus_err.
  - DM_stall=0 that cycle.
  - Next state is HOLD if IM_stall=1, otherwise IDLE.
- WR_AW: AWVALID and WVALID drop independently on their own handshakes (aw_done, w_done). Once both are done, go to WR_B with BREADY=1.
- WR_B: on BVALID, complete.
  - BRESP != 0 sets bus_err.
  - Next state is HOLD if IM_stall=1, otherwise IDLE.
- HOLD: DM_stall=0 and DM_DO is held. No new request is accepted, so the same MEM-stage instruction is never reissued. Return to IDLE when IM_stall=0.
- Minimum latency:
  - Load: 2 stall cycles, with ARREADY high at once and RVALID the next cycle.
  - Store: 2 stall cycles.
- Back-to-back requests: a new request can be accepted in the IDLE cycle immediately after completion.
- VALID stability: VALID stays high until its handshake and is never withdrawn, regardless of changes on the CPU inputs.
- Reset mid-transaction: the FSM aborts immediately. Bus-side recovery is the interconnect's responsibility.
- IDs and RLAST: RID/BID mismatch is ignored. RLAST is ignored because single-beat transfers are guaranteed.

Optional Feature:
- Macro: DM_AXI_BRIDGE_PERF_EN.
- When defined, adds three 32-bit outputs, all reset to 0 and wrapping at 2^32:
  - perf_rd_cnt: incremented on each load completion.
  - perf_wr_cnt: incremented on each store completion (zero-strobe stores included).
  - perf_stall_cnt: incremented on each cycle with DM_stall=1.
- When undefined: none of these ports or registers exist, and behaviour is otherwise identical.

Decomposition:
- Shared package dm_bridge_pkg:
  - Enum dm_state_t.
  - Constants AXI_SIZE_WORD=3'b010, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00.
- One natural sub-module, dm_perf_cnt (the three counters), instantiated only under the macro.

Test Plan:
- Load, zero-wait slave (ARREADY=1, RVALID one cycle later, RDATA=32'h1234_5678, RRESP=0) -> DM_stall high exactly 2 cycles; DM_DO=32'h1234_5678 on the completion cycle; bus_err=0.
- Store with DM_BWEB=4'b1100, DM_DI=32'hA5A5_0F0F:
  - Case AWREADY on cycle 1, WREADY on cycle 3 -> WSTRB=4'b0011; BREADY is raised only after both handshakes.
  - Case reversed order (WREADY first) -> same completion.
- Store with DM_BWEB=4'hF -> no AWVALID/WVALID; DM_stall stays 0.
- Load completes while IM_stall=1 for 3 more cycles -> FSM in HOLD; exactly one AR handshake; DM_DO stable; DM_stall=0.
- Store completes with BRESP=2'b10 -> bus_err=1 and remains 1 across following transactions until rst low.
- rst low asynchronously while in RD_D -> ARVALID/RREADY/DM_stall go to 0 immediately; DM_DO=0.
